// File: rtl/game_pkg.sv
// Shared encodings, timing defaults and BCD helpers for the game controller.
package game_pkg;

  localparam int unsigned TICK_DIV_DEF  = 20;
  localparam int unsigned BLINK_DIV_DEF = 100;

  localparam logic [15:0] SPEED_T1 = 16'h0100;
  localparam logic [15:0] SPEED_T2 = 16'h0300;
  localparam logic [15:0] SPEED_T3 = 16'h0600;
  localparam logic [15:0] BCD_MAX  = 16'h9999;

  typedef enum logic [1:0] {
    GS_IDLE  = 2'd0,
    GS_RUN   = 2'd1,
    GS_PAUSE = 2'd2,
    GS_OVER  = 2'd3
  } game_state_e;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_RUN   = 3'd2,
    S_PAUSE = 3'd3,
    S_OVER  = 3'd4
  } state_e;

  // Digit-wise magnitude compare, most significant digit decides first.
  function automatic logic bcd_gt(input logic [15:0] a, input logic [15:0] b);
    logic gt;
    logic decided;
    gt      = 1'b0;
    decided = 1'b0;
    for (int i = 3; i >= 0; i--) begin
      if (!decided && (a[i*4 +: 4] != b[i*4 +: 4])) begin
        gt      = (a[i*4 +: 4] > b[i*4 +: 4]);
        decided = 1'b1;
      end
    end
    return gt;
  endfunction

  function automatic logic bcd_lt(input logic [15:0] a, input logic [15:0] b);
    return bcd_gt(b, a);
  endfunction

endpackage

// File: rtl/bcd_counter4.sv
// Four-digit BCD up-counter with synchronous clear and saturation at 9999.
module bcd_counter4
  import game_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        clr_i,
  input  logic        inc_i,
  output logic [15:0] value_o
);

  logic [15:0] cnt_q, cnt_d;
  logic        carry;

  always_comb begin
    cnt_d = cnt_q;
    carry = 1'b0;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != BCD_MAX)) begin
      carry = 1'b1;
      for (int i = 0; i < 4; i++) begin
        if (carry) begin
          if (cnt_q[i*4 +: 4] == 4'd9) begin
            cnt_d[i*4 +: 4] = 4'd0;
          end else begin
            cnt_d[i*4 +: 4] = cnt_q[i*4 +: 4] + 4'd1;
            carry           = 1'b0;
          end
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign value_o = cnt_q;

endmodule

// File: rtl/game_ctrl.sv
// Game sequencer: start/pause/collision handling, score ticking, high score and game-over blink.
// state   | meaning
// S_IDLE  | waiting for first start press
// S_CLEAR | one-cycle hero/obstacle reset, score cleared
// S_RUN   | game active, score ticking
// S_PAUSE | enables off, score and tick frozen
// S_OVER  | game ended, display blinks until restart
module game_ctrl
  import game_pkg::*;
#(
  parameter int unsigned TICK_DIV  = TICK_DIV_DEF,
  parameter int unsigned BLINK_DIV = BLINK_DIV_DEF
) (
  input  logic        clk_5ms,
  input  logic        reset,
  input  logic        start_btn,
  input  logic        pause_btn,
  input  logic        collision,
  output logic        hero_enable,
  output logic        hero_reset,
  output logic        obstacle_enable,
  output logic [15:0] score,
  output logic [15:0] high_score,
  output logic [1:0]  speed_level,
  output logic [1:0]  game_state,
  output logic        over_blink
);

  localparam int unsigned TW = $clog2(TICK_DIV + 1);
  localparam int unsigned BW = $clog2(BLINK_DIV + 1);

  state_e      state_q, state_d;
  logic        start_prev_q, pause_prev_q;
  logic        start_press, pause_press;
  logic [TW-1:0] tick_q, tick_d;
  logic        tick_wrap;
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic        over_blink_q, over_blink_d;
  logic        hero_en_q, hero_en_d;
  logic        obst_en_q, obst_en_d;
  logic        hero_rst_q, hero_rst_d;
  logic [15:0] high_q, high_d;
  logic        run_hold;
  logic        score_clr;
  game_state_e gs;

  assign start_press = start_btn & ~start_prev_q;
  assign pause_press = pause_btn & ~pause_prev_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start_press) state_d = S_CLEAR;
      S_CLEAR: state_d = S_RUN;
      S_RUN: begin
        if (collision)        state_d = S_OVER;
        else if (pause_press) state_d = S_PAUSE;
      end
      S_PAUSE: if (pause_press) state_d = S_RUN;
      S_OVER:  if (start_press) state_d = S_CLEAR;
      default: state_d = S_IDLE;
    endcase
  end

  // Counting stops on the exit cycle so the final score equals what high_score captures.
  assign run_hold  = (state_q == S_RUN) && (state_d == S_RUN);
  assign score_clr = (state_d == S_CLEAR);

  always_comb begin
    tick_d    = tick_q;
    tick_wrap = 1'b0;
    if (score_clr) begin
      tick_d = '0;
    end else if (run_hold) begin
      if (tick_q == TW'(TICK_DIV - 1)) begin
        tick_d    = '0;
        tick_wrap = 1'b1;
      end else begin
        tick_d = tick_q + TW'(1);
      end
    end
  end

  always_comb begin
    blink_cnt_d  = '0;
    over_blink_d = 1'b0;
    if ((state_q == S_OVER) && (state_d == S_OVER)) begin
      over_blink_d = over_blink_q;
      if (blink_cnt_q == BW'(BLINK_DIV - 1)) begin
        blink_cnt_d  = '0;
        over_blink_d = ~over_blink_q;
      end else begin
        blink_cnt_d = blink_cnt_q + BW'(1);
      end
    end
  end

  always_comb begin
    high_d     = high_q;
    hero_en_d  = (state_d == S_RUN);
    obst_en_d  = (state_d == S_RUN);
    hero_rst_d = (state_d == S_CLEAR);
    if ((state_q == S_RUN) && (state_d == S_OVER) && bcd_gt(score, high_q)) begin
      high_d = score;
    end
  end

  always_ff @(posedge clk_5ms) begin
    if (reset) begin
      state_q      <= S_IDLE;
      start_prev_q <= start_btn;
      pause_prev_q <= pause_btn;
      tick_q       <= '0;
      blink_cnt_q  <= '0;
      over_blink_q <= 1'b0;
      hero_en_q    <= 1'b0;
      obst_en_q    <= 1'b0;
      hero_rst_q   <= 1'b1;
      high_q       <= '0;
    end else begin
      state_q      <= state_d;
      start_prev_q <= start_btn;
      pause_prev_q <= pause_btn;
      tick_q       <= tick_d;
      blink_cnt_q  <= blink_cnt_d;
      over_blink_q <= over_blink_d;
      hero_en_q    <= hero_en_d;
      obst_en_q    <= obst_en_d;
      hero_rst_q   <= hero_rst_d;
      high_q       <= high_d;
    end
  end

  bcd_counter4 u_score (
    .clk_i   (clk_5ms),
    .rst_i   (reset),
    .clr_i   (score_clr),
    .inc_i   (tick_wrap),
    .value_o (score)
  );

  always_comb begin
    gs = GS_IDLE;
    case (state_q)
      S_IDLE:         gs = GS_IDLE;
      S_CLEAR, S_RUN: gs = GS_RUN;
      S_PAUSE:        gs = GS_PAUSE;
      S_OVER:         gs = GS_OVER;
      default:        gs = GS_IDLE;
    endcase
  end

  always_comb begin
    speed_level = 2'd3;
    if (bcd_lt(score, SPEED_T1))      speed_level = 2'd0;
    else if (bcd_lt(score, SPEED_T2)) speed_level = 2'd1;
    else if (bcd_lt(score, SPEED_T3)) speed_level = 2'd2;
  end

  assign game_state      = gs;
  assign hero_enable     = hero_en_q;
  assign obstacle_enable = obst_en_q;
  assign hero_reset      = hero_rst_q;
  assign high_score      = high_q;
  assign over_blink      = over_blink_q;

endmodule

// File: doc/game_ctrl.md
GAME_CTRL -- requirements
Module: game_ctrl

Interface
REQ-001 SHALL have parameter TICK_DIV, default 20, meaning clk_5ms cycles per score tick (100 ms).
REQ-002 SHALL have parameter BLINK_DIV, default 100, meaning clk_5ms cycles per game-over blink toggle (500 ms).
REQ-003 SHALL have port clk_5ms  input  1  200 Hz system clock, the only clock.
REQ-004 SHALL have port reset  input  1  synchronous active-high reset, sampled on posedge clk_5ms.
REQ-005 SHALL have port start_btn  input  1  debounced start/restart level; a press is its rising edge.
REQ-006 SHALL have port pause_btn  input  1  debounced pause level; a press is its rising edge.
REQ-007 SHALL have port collision  input  1  hero/obstacle overlap level from the collision checker.
REQ-008 SHALL have port hero_enable  output  1  enable to the hero block.
REQ-009 SHALL have port hero_reset  output  1  one-cycle reset pulse to the hero and obstacle blocks.
REQ-010 SHALL have port obstacle_enable  output  1  enable to the obstacle generator.
REQ-011 SHALL have port score  output  16  four-digit BCD current score.
REQ-012 SHALL have port high_score  output  16  four-digit BCD best score since reset.
REQ-013 SHALL have port speed_level  output  2  obstacle speed select, 0 to 3.
REQ-014 SHALL have port game_state  output  2  encoding IDLE=0, RUN=1, PAUSE=2, OVER=3.
REQ-015 SHALL have port over_blink  output  1  blink flag for the game-over display.

Function
REQ-016 SHALL implement the FSM states IDLE, CLEAR, RUN, PAUSE and OVER; game_state SHALL report RUN while in CLEAR.
REQ-017 SHALL detect a button press by comparing registered previous and current levels; one press SHALL yield exactly one event.
REQ-018 SHALL take these transitions:
- IDLE to CLEAR on a start press.
- OVER to CLEAR on a start press.
- CLEAR to RUN unconditionally after one cycle.
REQ-019 SHALL, in CLEAR: assert hero_reset for that single cycle, clear score to 0000 and the tick counter to 0, and hold the enables low.
REQ-020 SHALL, in RUN: assert hero_enable and obstacle_enable; the tick counter counts 0 to TICK_DIV-1 and wraps; score increments by 1 (BCD) on each wrap.
REQ-021 SHALL transition RUN to OVER on collision=1 and RUN to PAUSE on a pause press; collision SHALL take priority when both occur in the same cycle.
REQ-022 SHALL, in PAUSE: deassert both enables and freeze the score and tick counter; a pause press SHALL return to RUN with the tick counter resumed, not cleared.
REQ-023 SHALL ignore collision and start presses in PAUSE, and ignore pause presses in IDLE, CLEAR and OVER.
REQ-024 SHALL saturate score at 9999; further ticks leave it unchanged.
REQ-025 SHALL, on the cycle of the RUN to OVER transition, load high_score from score if score > high_score (BCD magnitude compare, most significant digit first).
REQ-026 SHALL derive speed_level combinationally from score: 0 if <0100, 1 if <0300, 2 if <0600, otherwise 3.
REQ-027 SHALL toggle over_blink every BLINK_DIV cycles in OVER, and hold it at 0 in all other states; the blink counter clears on entry to OVER.
REQ-028 SHALL register all outputs except speed_level and game_state decode.

Reset
REQ-029 SHALL, on reset=1 at a clock edge, set the following regardless of state:
- state to IDLE
- score, high_score and all counters to 0
- hero_enable, obstacle_enable and over_blink to 0
- hero_reset to 1 for that cycle
- button history registers to their current input levels, so a held button produces no event
REQ-030 SHALL give reset priority over every other input, including mid-RUN and mid-OVER.

Structure
REQ-031 SHALL place the state encodings, TICK_DIV and BLINK_DIV defaults, and the speed thresholds 0100/0300/0600 in shared package game_pkg.
REQ-032 SHALL implement the score as sub-module bcd_counter4 (synchronous clear, increment enable, 9999 saturation, 16-bit BCD output), instantiated once.
REQ-033 SHALL fit in 120-400 lines of RTL including bcd_counter4.

Verification
REQ-034 SHALL cover this scenario: reset, start press, hold RUN for 2000 cycles -> one hero_reset pulse in CLEAR, score=0100, speed_level=1.
REQ-035 SHALL cover this scenario: RUN at score 0042, pause press, wait 500 cycles, pause press, wait 20 cycles -> score stays 0042 through PAUSE, then 0043, enables low only during PAUSE.
REQ-036 SHALL cover this scenario: pause press and collision in the same RUN cycle -> next state OVER, high_score updated, never PAUSE.
REQ-037 SHALL cover this scenario: force score 9998, run 60 cycles -> score 9999 and held, speed_level=3.
REQ-038 SHALL cover this scenario: game one ends at 0300, game two at 0150 -> high_score=0300 after both; over_blink toggles at 100-cycle spacing in OVER.
REQ-039 SHALL cover this scenario: start_btn held high through reset release -> stays IDLE until released and pressed again.
